median9_pipe: RTL and testbench



---
 rtl/median9_pipe.sv | 175 +++++++++++++++++
 tb/tb_median9_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median9_pipe.sv
// Three-stage pipelined 3x3 rank filter (median/min/max/centre) with CHANNELS independent lanes.
// Bubble-collapsing valid/ready flow control; the last flag rides alongside the data.
module median9_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             inValid,
    output logic                             inReady,
    input  logic [DATA_WIDTH*9*CHANNELS-1:0] inData,
    input  logic [1:0]                       inMode,
    input  logic                             inLast,
    output logic                             outValid,
    input  logic                             outReady,
    output logic [DATA_WIDTH*CHANNELS-1:0]   outData,
    output logic                             outLast
);
    localparam int DW = DATA_WIDTH;
    typedef logic [DW-1:0] sample_t;

    function automatic sample_t min2(input sample_t a, input sample_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic sample_t max2(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic sample_t med3(input sample_t a, input sample_t b, input sample_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Handshake: a beat moves across a boundary on a cycle where the sender's valid and the
    // receiver's ready are both 1. valid never waits on ready; a stage is ready when it is
    // empty or its own contents leave this cycle, so ready ripples combinationally from
    // outReady back to inReady.
    logic       r_s1_valid, r_s2_valid, r_s3_valid;
    logic [1:0] r_s1_mode, r_s2_mode;
    logic       r_s1_last, r_s2_last, r_s3_last;
    logic       w_s1_load, w_s2_load, w_s3_load;
    logic       w_s1_move, w_s2_move, w_s3_move;

    sample_t r_s1_hi  [CHANNELS][3];
    sample_t r_s1_mid [CHANNELS][3];
    sample_t r_s1_lo  [CHANNELS][3];
    sample_t r_s1_ctr [CHANNELS];
    sample_t w_s1_hi  [CHANNELS][3];
    sample_t w_s1_mid [CHANNELS][3];
    sample_t w_s1_lo  [CHANNELS][3];
    sample_t w_s1_ctr [CHANNELS];

    sample_t r_s2_low_max  [CHANNELS];
    sample_t r_s2_mid_med  [CHANNELS];
    sample_t r_s2_high_min [CHANNELS];
    sample_t r_s2_gmin     [CHANNELS];
    sample_t r_s2_gmax     [CHANNELS];
    sample_t r_s2_ctr      [CHANNELS];
    sample_t w_s2_low_max  [CHANNELS];
    sample_t w_s2_mid_med  [CHANNELS];
    sample_t w_s2_high_min [CHANNELS];
    sample_t w_s2_gmin     [CHANNELS];
    sample_t w_s2_gmax     [CHANNELS];

    logic [DW*CHANNELS-1:0] r_s3_data;
    logic [DW*CHANNELS-1:0] w_s3_data;

    assign w_s3_move = r_s3_valid && outReady;
    assign w_s3_load = !r_s3_valid || w_s3_move;
    assign w_s2_move = r_s2_valid && w_s3_load;
    assign w_s2_load = !r_s2_valid || w_s2_move;
    assign w_s1_move = r_s1_valid && w_s2_load;
    assign w_s1_load = !r_s1_valid || w_s1_move;

    assign inReady  = w_s1_load;
    assign outValid = r_s3_valid;
    assign outData  = r_s3_data;
    assign outLast  = r_s3_last;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign w_s1_ctr[c] = inData[(c*9 + 4)*DW +: DW];

        for (genvar r = 0; r < 3; r++) begin : g_row
            sample_t w_a, w_b, w_c;
            assign w_a = inData[(c*9 + 3*r)*DW +: DW];
            assign w_b = inData[(c*9 + 3*r + 1)*DW +: DW];
            assign w_c = inData[(c*9 + 3*r + 2)*DW +: DW];
            assign w_s1_hi[c][r]  = max2(max2(w_a, w_b), w_c);
            assign w_s1_mid[c][r] = med3(w_a, w_b, w_c);
            assign w_s1_lo[c][r]  = min2(min2(w_a, w_b), w_c);
        end

        assign w_s2_low_max[c]  = max2(max2(r_s1_lo[c][0], r_s1_lo[c][1]), r_s1_lo[c][2]);
        assign w_s2_mid_med[c]  = med3(r_s1_mid[c][0], r_s1_mid[c][1], r_s1_mid[c][2]);
        assign w_s2_high_min[c] = min2(min2(r_s1_hi[c][0], r_s1_hi[c][1]), r_s1_hi[c][2]);
        assign w_s2_gmin[c]     = min2(min2(r_s1_lo[c][0], r_s1_lo[c][1]), r_s1_lo[c][2]);
        assign w_s2_gmax[c]     = max2(max2(r_s1_hi[c][0], r_s1_hi[c][1]), r_s1_hi[c][2]);

        assign w_s3_data[c*DW +: DW] =
            (r_s2_mode == 2'd0) ? med3(r_s2_low_max[c], r_s2_mid_med[c], r_s2_high_min[c]) :
            (r_s2_mode == 2'd1) ? r_s2_gmin[c] :
            (r_s2_mode == 2'd2) ? r_s2_gmax[c] :
                                  r_s2_ctr[c];
    end

    // S1: row sorts. Data registers only load real beats so they hold steady across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 2'd0;
            r_s1_last  <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_s1_ctr[c] <= '0;
                for (int r = 0; r < 3; r++) begin
                    r_s1_hi[c][r]  <= '0;
                    r_s1_mid[c][r] <= '0;
                    r_s1_lo[c][r]  <= '0;
                end
            end
        end else if (w_s1_load) begin
            r_s1_valid <= inValid;
            if (inValid) begin
                r_s1_mode <= inMode;
                r_s1_last <= inLast;
                r_s1_hi   <= w_s1_hi;
                r_s1_mid  <= w_s1_mid;
                r_s1_lo   <= w_s1_lo;
                r_s1_ctr  <= w_s1_ctr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mode  <= 2'd0;
            r_s2_last  <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_s2_low_max[c]  <= '0;
                r_s2_mid_med[c]  <= '0;
                r_s2_high_min[c] <= '0;
                r_s2_gmin[c]     <= '0;
                r_s2_gmax[c]     <= '0;
                r_s2_ctr[c]      <= '0;
            end
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mode     <= r_s1_mode;
                r_s2_last     <= r_s1_last;
                r_s2_low_max  <= w_s2_low_max;
                r_s2_mid_med  <= w_s2_mid_med;
                r_s2_high_min <= w_s2_high_min;
                r_s2_gmin     <= w_s2_gmin;
                r_s2_gmax     <= w_s2_gmax;
                r_s2_ctr      <= r_s1_ctr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_s3_data  <= '0;
        end else if (w_s3_load) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_last <= r_s2_last;
                r_s3_data <= w_s3_data;
            end
        end
    end

endmodule

// File: tb/tb_median9_pipe.sv
// Bench for median9_pipe: randomized and directed beats scored against a sort-based rank model.
// Three lanes are instantiated so every test also exercises lane independence.
module tb_median9_pipe;
    localparam int DW = 8;
    localparam int CH = 3;
    localparam int W  = DW*CH + 1;
    localparam int IW = 9*DW*CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inValid;
    logic          inReady;
    logic [IW-1:0] inData;
    logic [1:0]    inMode;
    logic          inLast;
    logic          outValid;
    logic          outReady;
    logic [DW*CH-1:0] outData;
    logic          outLast;

    always #5 clk = ~clk;

    median9_pipe #(.DATA_WIDTH(DW), .CHANNELS(CH)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady), .inData(inData), .inMode(inMode), .inLast(inLast),
        .outValid(outValid), .outReady(outReady), .outData(outData), .outLast(outLast)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           acc_t_q[$];
    int           rdy_mode = 0;
    int           rdy_idx = 0;
    logic [3:0]   rdy_pat = 4'b1001;
    bit           lat_chk = 1'b0;
    bit           mon_en = 1'b0;
    logic [W-1:0] mon_e;
    int           mon_t;
    int           vals[9];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: rank the nine samples of a lane by sorting them.
    function automatic logic [DW-1:0] ref_lane(input logic [9*DW-1:0] w, input logic [1:0] m);
        int q[$];
        int pick;
        logic [DW-1:0] res;
        for (int i = 0; i < 9; i++) q.push_back(int'(w[i*DW +: DW]));
        q.sort();
        case (m)
            2'd0:    pick = q[4];
            2'd1:    pick = q[0];
            2'd2:    pick = q[8];
            default: pick = int'(w[4*DW +: DW]);
        endcase
        res = pick[DW-1:0];
        return res;
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic [IW-1:0] d, input logic [1:0] m,
                                              input logic l);
        logic [W-1:0] e;
        e[W-1] = l;
        for (int c = 0; c < CH; c++) e[c*DW +: DW] = ref_lane(d[c*9*DW +: 9*DW], m);
        return e;
    endfunction

    function automatic logic [9*DW-1:0] win9(input int v[9]);
        logic [9*DW-1:0] w;
        for (int i = 0; i < 9; i++) w[i*DW +: DW] = v[i][DW-1:0];
        return w;
    endfunction

    function automatic logic [IW-1:0] rep(input logic [9*DW-1:0] w);
        logic [IW-1:0] d;
        for (int c = 0; c < CH; c++) d[c*9*DW +: 9*DW] = w;
        return d;
    endfunction

    function automatic logic [IW-1:0] rand_data();
        logic [IW-1:0] d;
        for (int i = 0; i < 9*CH; i++) d[i*DW +: DW] = DW'($urandom_range(0, 255));
        return d;
    endfunction

    // Downstream ready: 0 always, 1 the 1-0-0-1 pattern, 2 random, 3 stalled.
    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: outReady = 1'b1;
                1: begin
                    outReady = rdy_pat[rdy_idx % 4];
                    rdy_idx++;
                end
                2: outReady = 1'($urandom_range(0, 1));
                default: outReady = 1'b0;
            endcase
        end
    end

    // Scoreboard sampled mid-cycle: handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && mon_en) begin
            chk("in_ready", inReady, !(exp_q.size() >= 3 && !outReady));
            if (outValid && outReady) begin
                got_q.push_back({outLast, outData});
                if (exp_q.size() == 0) begin
                    chk("spurious_out", outValid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_t = acc_t_q.pop_front();
                    chk("out_beat", {outLast, outData}, mon_e);
                    if (lat_chk) chk("latency", cyc - mon_t, 3);
                end
            end
            if (inValid && inReady) begin
                exp_q.push_back(ref_beat(inData, inMode, inLast));
                acc_t_q.push_back(cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [IW-1:0] d, input logic [1:0] m, input logic l);
        bit acc;
        acc = 1'b0;
        inValid = 1'b1;
        inData  = d;
        inMode  = m;
        inLast  = l;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = inReady;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 32'(acc), 1);
        inValid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && exp_q.size() > 0; k++) idle(1);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [9*DW-1:0] base;
        logic [IW-1:0]   d;
        logic [DW-1:0]   basic_exp[4];
        logic [DW-1:0]   ext_exp[7];

        inValid = 1'b0;
        inData  = '0;
        inMode  = 2'd0;
        inLast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", outValid, 1'b0);
        chk("rst_out_data", outData, 0);
        chk("rst_out_last", outLast, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", inReady, 1'b1);
        idle(1);
        mon_en = 1'b1;

        // Basic modes, back to back, downstream always ready.
        vals = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
        base = win9(vals);
        basic_exp = '{8'd5, 8'd1, 8'd9, 8'd7};
        lat_chk = 1'b1;
        got_q.delete();
        for (int m = 0; m < 4; m++) send_beat(rep(base), 2'(m), 1'b0);
        drain();
        chk("basic_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) chk("basic_mode", got_q[i], {1'b0, {CH{basic_exp[i]}}});

        // Extremes and ties.
        got_q.delete();
        send_beat('0, 2'd0, 1'b0);
        send_beat({IW{1'b1}}, 2'd0, 1'b0);
        vals = '{0, 255, 255, 255, 255, 255, 255, 255, 255};
        send_beat(rep(win9(vals)), 2'd0, 1'b0);
        for (int m = 0; m < 4; m++) send_beat({(9*CH){8'h5a}}, 2'(m), 1'b0);
        drain();
        ext_exp = '{8'd0, 8'd255, 8'd255, 8'h5a, 8'h5a, 8'h5a, 8'h5a};
        chk("ext_count", got_q.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < got_q.size()) chk("extreme", got_q[i], {1'b0, {CH{ext_exp[i]}}});
        lat_chk = 1'b0;

        // Multi-lane: lane 0 base window, lane 1 0..8, lane 2 8..0.
        got_q.delete();
        d[0 +: 9*DW] = base;
        vals = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        d[9*DW +: 9*DW] = win9(vals);
        vals = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
        d[18*DW +: 9*DW] = win9(vals);
        send_beat(d, 2'd0, 1'b0);
        drain();
        chk("multi_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("multi_lane", got_q[0], {1'b0, 8'd4, 8'd4, 8'd5});

        // Backpressure with the 1-0-0-1 ready pattern.
        got_q.delete();
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            send_beat(rand_data(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        chk("bp_count", got_q.size(), 10);

        // Sideband under random stalls: last only on the 5th beat.
        got_q.delete();
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) send_beat(rand_data(), 2'($urandom_range(0, 3)), 1'(i == 4));
        drain();
        chk("sb_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got_q.size()) chk("sideband_last", got_q[i][W-1], 1'(i == 4));

        // Random soak with gaps and random stalls.
        got_q.delete();
        for (int i = 0; i < 200; i++) begin
            send_beat(rand_data(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        drain();
        chk("soak_count", got_q.size(), 200);

        // Reset with a full, stalled pipeline.
        rdy_mode = 3;
        idle(2);
        for (int i = 0; i < 3; i++) send_beat(rand_data(), 2'd0, 1'b1);
        chk("full_in_ready", inReady, 1'b0);
        chk("full_out_valid", outValid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", outValid, 1'b0);
        chk("mid_rst_data", outData, 0);
        chk("mid_rst_last", outLast, 1'b0);
        exp_q.delete();
        acc_t_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", inReady, 1'b1);
        rdy_mode = 0;
        idle(6);
        chk("no_stale", got_q.size(), 0);
        for (int i = 0; i < 4; i++) send_beat(rand_data(), 2'($urandom_range(0, 3)), 1'b0);
        drain();
        chk("post_rst_count", got_q.size(), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
